uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 183 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling and byte strobe
//
// Purpose: samples the asynchronous UART_RX line, finds each bit centre from a
// falling start edge, assembles LSB-first bytes and strobes each good byte out.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with even-parity check).
//
// Ports:
//   sysclk     in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   UART_RX    in   serial line, idle high, asynchronous to sysclk
//   RX_DATA    out  [7:0] last correctly framed byte (held until next good byte)
//   RX_STATUS  out  one-cycle pulse when RX_DATA is updated
//   RX_BUSY    out  high while a frame is in progress
//   RX_ERR     out  one-cycle pulse on framing (or parity) error
module uart_receiver #(
   parameter int CLKS_PER_TICK = 651,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       UART_RX,
   output logic [7:0] RX_DATA,
   output logic       RX_STATUS,
   output logic       RX_BUSY,
   output logic       RX_ERR
);

   localparam int DW   = $clog2(CLKS_PER_TICK);
   localparam int TW   = $clog2(TICKS_PER_BIT);
   localparam int HALF = TICKS_PER_BIT / 2;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t         state_q, state_d;
   logic           sync1_q, sync1_d;
   logic           rx_s_q, rx_s_d;
   logic           rx_prev_q, rx_prev_d;
   logic [DW-1:0]  div_q, div_d;
   logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     data_q, data_d;
   logic           status_q, status_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic           par_q, par_d;
`endif
   logic           tick;
   logic           bit_end;
   logic           frame_ok;

   // Divider is held at 0 in IDLE, so the tick phase is locked to the start edge.
   assign tick    = (div_q == DW'(CLKS_PER_TICK - 1));
   assign bit_end = tick && (tick_cnt_q == TW'(TICKS_PER_BIT - 1));

`ifdef UART_RX_PARITY_EN
   assign frame_ok = rx_s_q && !(^{shift_q, par_q});
`else
   assign frame_ok = rx_s_q;
`endif

   always_comb begin
      state_d    = state_q;
      sync1_d    = UART_RX;
      rx_s_d     = sync1_q;
      rx_prev_d  = rx_s_q;
      div_d      = (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      status_d   = 1'b0;
      err_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d      = par_q;
`endif
      if (tick) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               state_d    = S_START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
            end
         end
         S_START: begin
            // Mid start bit: a high line here means the edge was a glitch.
            if (tick && tick_cnt_q == TW'(HALF - 1)) begin
               tick_cnt_d = '0;
               state_d    = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               tick_cnt_d = '0;
               shift_d    = {rx_s_q, shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               tick_cnt_d = '0;
               par_d      = rx_s_q;
               state_d    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               tick_cnt_d = '0;
               state_d    = S_IDLE;
               if (frame_ok) begin
                  data_d   = shift_q;
                  status_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         div_q      <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         status_q   <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         rx_s_q     <= rx_s_d;
         rx_prev_q  <= rx_prev_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         status_q   <= status_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign RX_DATA   = data_q;
   assign RX_STATUS = status_q;
   assign RX_ERR    = err_q;
   assign RX_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard testbench for uart_receiver
module tb_uart_receiver;

   localparam int CPT = 4;
   localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
   localparam int  LAT    = 675;
   localparam bit  PARITY = 1'b1;
`else
   localparam int  LAT    = 611;
   localparam bit  PARITY = 1'b0;
`endif

   logic       sysclk  = 1'b0;
   logic       reset   = 1'b1;
   logic       UART_RX = 1'b1;
   logic [7:0] RX_DATA;
   logic       RX_STATUS;
   logic       RX_BUSY;
   logic       RX_ERR;

   uart_receiver #(.CLKS_PER_TICK(CPT), .TICKS_PER_BIT(16)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .UART_RX   (UART_RX),
      .RX_DATA   (RX_DATA),
      .RX_STATUS (RX_STATUS),
      .RX_BUSY   (RX_BUSY),
      .RX_ERR    (RX_ERR)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      int         fall;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_data = 8'h00;
   logic       busy_seen  = 1'b0;

   task automatic check(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
   endtask

   always @(negedge sysclk) if (RX_BUSY) busy_seen = 1'b1;

   // Monitor: every output pulse pops the next expected frame result.
   always @(negedge sysclk) begin
      exp_t e;
      if (!reset && (RX_STATUS || RX_ERR)) begin
         check("status_err_exclusive", int'(RX_STATUS & RX_ERR), 0, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0, 0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_is_err", int'(RX_ERR), int'(e.is_err), int'(e.is_err));
            check("pulse_rx_data", int'(RX_DATA), int'(e.data), int'(e.data));
            check("pulse_latency", cyc - e.fall, LAT - 6, LAT);
         end
      end
   end

   task automatic send_bit(input logic v, input int len);
      UART_RX = v;
      repeat (len) @(posedge sysclk);
      #1;
   endtask

   task automatic idle(input int n);
      UART_RX = 1'b1;
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                             input logic par_flip);
      exp_t e;
      logic bad;
      bad = !stop_v || (PARITY && par_flip);
      if (!bad) model_data = d;
      e.is_err = bad;
      e.data   = model_data;
      e.fall   = cyc;
      exp_q.push_back(e);
      send_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip, BIT);
`endif
      send_bit(stop_v, stop_len);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge sysclk);
      #1;
      check("reset_rx_data", int'(RX_DATA), 0, 0);
      check("reset_rx_status", int'(RX_STATUS), 0, 0);
      check("reset_rx_err", int'(RX_ERR), 0, 0);
      check("reset_rx_busy", int'(RX_BUSY), 0, 0);
      reset = 1'b0;

      busy_seen = 1'b0;
      idle(1000);
      check("idle_busy_never_high", int'(busy_seen), 0, 0);
      check("idle_rx_data", int'(RX_DATA), 0, 0);

      send_frame(8'hA5, 1'b1, BIT, 1'b0);
      idle(100);
      check("a5_rx_data", int'(RX_DATA), 'hA5, 'hA5);

      send_frame(8'h00, 1'b1, 40, 1'b0);
      send_frame(8'hFF, 1'b1, 40, 1'b0);
      send_frame(8'h3C, 1'b1, BIT, 1'b0);
      idle(100);
      check("b2b_rx_data", int'(RX_DATA), 'h3C, 'h3C);

      busy_seen = 1'b0;
      send_bit(1'b0, 20);
      idle(20);
      check("glitch_busy_pulsed", int'(busy_seen), 1, 1);
      check("glitch_busy_cleared", int'(RX_BUSY), 0, 0);
      idle(100);

      send_frame(8'h55, 1'b0, BIT, 1'b0);
      idle(200);
      check("ferr_rx_data_held", int'(RX_DATA), 'h3C, 'h3C);
      send_frame(8'h12, 1'b1, BIT, 1'b0);
      idle(100);
      check("after_ferr_rx_data", int'(RX_DATA), 'h12, 'h12);

      // 0x81 aborted by reset in the middle of bit 4; reset held until the line idles.
      send_bit(1'b0, BIT);
      send_bit(1'b1, BIT);
      send_bit(1'b0, BIT);
      send_bit(1'b0, BIT);
      send_bit(1'b0, BIT);
      send_bit(1'b0, 32);
      reset = 1'b1;
      send_bit(1'b0, 32);
      check("abort_rx_data", int'(RX_DATA), 0, 0);
      check("abort_rx_busy", int'(RX_BUSY), 0, 0);
      send_bit(1'b0, BIT);
      send_bit(1'b0, BIT);
      send_bit(1'b1, BIT);
      send_bit(1'b1, BIT);
      idle(20);
      reset = 1'b0;
      model_data = 8'h00;
      idle(20);
      send_frame(8'h81, 1'b1, BIT, 1'b0);
      idle(100);
      check("post_abort_rx_data", int'(RX_DATA), 'h81, 'h81);
`ifdef UART_RX_PARITY_EN
      send_frame(8'h81, 1'b1, BIT, 1'b1);
      idle(100);
      check("parity_err_rx_data", int'(RX_DATA), 'h81, 'h81);
`endif

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge sysclk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
